// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_port_arbiter_pkg                                                 |
// | Shared state encoding and requester indices for the RAM arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_IDX_0 = 1'b0;
  localparam logic REQ_IDX_1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                          |
// | Combinational two-way round-robin pick; ties go to the non-last one. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      if (last == REQ_IDX_0) gnt[1] = 1'b1;
      else                   gnt[0] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_port_arbiter                                                     |
// | Two requesters sharing one RAM port, round-robin with lock bursts.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [1:0]            arb_gnt;
  logic [1:0]            gnt;
  logic                  mem_we_c;

  rr_arbiter2 u_rr (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    gnt = 2'b00;
    case (state_q)
      IDLE:    gnt = arb_gnt;
      OWN0:    gnt[0] = req0;
      OWN1:    gnt[1] = req1;
      default: gnt = 2'b00;
    endcase
    // Nothing is granted while reset is being sampled.
    if (!rst_n) gnt = 2'b00;
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_c   = 1'b0;
    last_d     = last_q;
    if (gnt[0]) begin
      mem_addr_d = addr0;
      mem_din_d  = wdata0;
      mem_we_c   = we0;
      last_d     = REQ_IDX_0;
    end else if (gnt[1]) begin
      mem_addr_d = addr1;
      mem_din_d  = wdata1;
      mem_we_c   = we1;
      last_d     = REQ_IDX_1;
    end
    rvalid_d = {gnt[1] & ~we1, gnt[0] & ~we0};
    rdata0_d = rvalid_d[0] ? mem_dout : rdata0_q;
    rdata1_d = rvalid_d[1] ? mem_dout : rdata1_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt[0] && lock0)      state_d = OWN0;
        else if (gnt[1] && lock1) state_d = OWN1;
      end
      OWN0:    if (!lock0) state_d = IDLE;
      OWN1:    if (!lock1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= REQ_IDX_1;
      rvalid_q   <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  // A read granted just before reset must not surface its valid.
  assign rvalid0  = rvalid_q[0] & rst_n;
  assign rvalid1  = rvalid_q[1] & rst_n;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_addr = mem_addr_d;
  assign mem_din  = mem_din_d;
  assign mem_we   = mem_we_c;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_port_arbiter                                                  |
// | Vector-table bench for ram_port_arbiter with a dual-port RAM model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] ram [0:4095];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

  ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  typedef struct {
    logic        r0, w0, l0;
    logic [11:0] a0;
    logic [31:0] d0;
    logic        r1, w1, l1;
    logic [11:0] a1;
    logic [31:0] d1;
    logic [1:0]  eg;
    logic        ewe;
    logic [11:0] eaddr;
    logic [1:0]  erv;
    logic [31:0] erd0, erd1;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0, input logic l0,
    input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1, input logic l1,
    input logic [1:0] eg, input logic ewe, input logic [11:0] eaddr,
    input logic [1:0] erv, input logic [31:0] erd0, input logic [31:0] erd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
    v.eg = eg; v.ewe = ewe; v.eaddr = eaddr; v.erv = erv; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; lock0 = v.l0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; lock1 = v.l1;
  endtask

  task automatic apply(input int i, input vec_t v);
    drive(v);
    #2;
    chk($sformatf("v%0d_gnt", i), {30'd0, gnt1, gnt0}, {30'd0, v.eg});
    chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, v.ewe});
    chk($sformatf("v%0d_mem_addr", i), {20'd0, mem_addr}, {20'd0, v.eaddr});
    @(posedge clk); #1;
    chk($sformatf("v%0d_rvalid", i), {30'd0, rvalid1, rvalid0}, {30'd0, v.erv});
    chk($sformatf("v%0d_rdata0", i), rdata0, v.erd0);
    chk($sformatf("v%0d_rdata1", i), rdata1, v.erd1);
  endtask

  initial begin
    logic [1:0] tie_exp [4];
    vec_t idle_v;
    for (int k = 0; k < 4096; k++) ram[k] = 32'h0;
    ram[12'h010] = 32'hDEADBEEF;
    ram[12'h020] = 32'h0000_0011;
    ram[12'h030] = 32'h0000_A5A5;
    ram[12'h040] = 32'h0000_5A5A;

    //            r0 w0 a0      d0     l0  r1 w1 a1      d1     l1  eg     we addr    rv     rd0           rd1
    vt[0]  = mk(1, 0, 12'h010, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h010, 2'b01, 32'hDEADBEEF, 32'h0);
    vt[1]  = mk(0, 0, 12'h0,   32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b00, 0, 12'h010, 2'b00, 32'hDEADBEEF, 32'h0);
    vt[2]  = mk(1, 0, 12'h030, 32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b10, 0, 12'h040, 2'b10, 32'hDEADBEEF, 32'h5A5A);
    vt[3]  = mk(1, 0, 12'h030, 32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b01, 0, 12'h030, 2'b01, 32'hA5A5,     32'h5A5A);
    vt[4]  = mk(1, 0, 12'h030, 32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b10, 0, 12'h040, 2'b10, 32'hA5A5,     32'h5A5A);
    vt[5]  = mk(1, 1, 12'h050, 32'h77, 0, 0, 0, 12'h0,  32'h0, 0,  2'b01, 1, 12'h050, 2'b00, 32'hA5A5,     32'h5A5A);
    vt[6]  = mk(1, 0, 12'h050, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h050, 2'b01, 32'h77,       32'h5A5A);
    vt[7]  = mk(0, 0, 12'h0,   32'h0, 0,  1, 0, 12'h020, 32'h0, 0, 2'b10, 0, 12'h020, 2'b10, 32'h77,       32'h11);
    vt[8]  = mk(0, 0, 12'h0,   32'h0, 0,  1, 1, 12'h020, 32'h22, 0, 2'b10, 1, 12'h020, 2'b00, 32'h77,      32'h11);
    vt[9]  = mk(0, 0, 12'h0,   32'h0, 0,  1, 0, 12'h020, 32'h0, 0, 2'b10, 0, 12'h020, 2'b10, 32'h77,       32'h22);
    vt[10] = mk(1, 0, 12'h010, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h010, 2'b01, 32'hDEADBEEF, 32'h22);
    vt[11] = mk(1, 0, 12'h010, 32'h0, 0,  1, 1, 12'h100, 32'hA0, 1, 2'b10, 1, 12'h100, 2'b00, 32'hDEADBEEF, 32'h22);
    vt[12] = mk(1, 0, 12'h010, 32'h0, 0,  1, 1, 12'h101, 32'hA1, 1, 2'b10, 1, 12'h101, 2'b00, 32'hDEADBEEF, 32'h22);
    vt[13] = mk(1, 0, 12'h010, 32'h0, 0,  1, 1, 12'h102, 32'hA2, 1, 2'b10, 1, 12'h102, 2'b00, 32'hDEADBEEF, 32'h22);
    vt[14] = mk(1, 0, 12'h010, 32'h0, 0,  1, 1, 12'h103, 32'hA3, 0, 2'b10, 1, 12'h103, 2'b00, 32'hDEADBEEF, 32'h22);
    vt[15] = mk(1, 0, 12'h010, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h010, 2'b01, 32'hDEADBEEF, 32'h22);
    vt[16] = mk(1, 0, 12'h103, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h103, 2'b01, 32'hA3,       32'h22);
    vt[17] = mk(1, 0, 12'h100, 32'h0, 0,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h100, 2'b01, 32'hA0,       32'h22);
    vt[18] = mk(1, 0, 12'h030, 32'h0, 1,  0, 0, 12'h0,  32'h0, 0,  2'b01, 0, 12'h030, 2'b01, 32'hA5A5,     32'h22);
    vt[19] = mk(0, 0, 12'h0,   32'h0, 1,  1, 0, 12'h040, 32'h0, 0, 2'b00, 0, 12'h030, 2'b00, 32'hA5A5,     32'h22);
    vt[20] = vt[19];
    vt[21] = vt[19];
    vt[22] = mk(0, 0, 12'h0,   32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b00, 0, 12'h030, 2'b00, 32'hA5A5,     32'h22);
    vt[23] = mk(0, 0, 12'h0,   32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b10, 0, 12'h040, 2'b10, 32'hA5A5,     32'h5A5A);
    vt[24] = mk(0, 0, 12'h0,   32'h0, 1,  1, 0, 12'h040, 32'h0, 0, 2'b10, 0, 12'h040, 2'b10, 32'hA5A5,     32'h5A5A);
    vt[25] = mk(0, 0, 12'h0,   32'h0, 0,  1, 0, 12'h020, 32'h0, 0, 2'b10, 0, 12'h020, 2'b10, 32'hA5A5,     32'h22);
    vt[26] = mk(1, 0, 12'h010, 32'h0, 0,  1, 0, 12'h040, 32'h0, 0, 2'b01, 0, 12'h010, 2'b01, 32'hDEADBEEF, 32'h22);

    idle_v = mk(0, 0, 12'h0, 32'h0, 0, 0, 0, 12'h0, 32'h0, 0, 2'b00, 0, 12'h0, 2'b00, 32'h0, 32'h0);

    // Reset cycle: a pending write must be neither granted nor issued.
    drive(idle_v);
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h3FF; wdata0 = 32'h1234;
    #2;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    drive(idle_v);
    rst_n = 1'b1;
    #1;
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_ram_3ff", ram[12'h3FF], 32'd0);

    for (int i = 0; i < NV; i++) apply(i, vt[i]);

    // Tie straight out of reset: requester 0 first, then alternation.
    rst_n = 1'b0;
    drive(idle_v);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
    req0 = 1'b1; addr0 = 12'h010; req1 = 1'b1; addr1 = 12'h040;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("tie%0d_gnt", c), {30'd0, gnt1, gnt0}, {30'd0, tie_exp[c]});
      @(posedge clk); #1;
    end
    chk("tie_rdata0", rdata0, 32'hDEADBEEF);

    // Read granted, then reset sampled in the following cycle.
    drive(idle_v);
    req0 = 1'b1; addr0 = 12'h030;
    #2;
    chk("rstrd_gnt0", {31'd0, gnt0}, 32'd1);
    @(posedge clk); #1;
    drive(idle_v);
    rst_n = 1'b0;
    #1;
    chk("rstrd_rvalid0_t1", {31'd0, rvalid0}, 32'd0);
    @(posedge clk); #1;
    chk("rstrd_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rstrd_rdata0", rdata0, 32'd0);
    chk("rstrd_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstrd_mem_addr", {20'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: word width.
- ADDR_WIDTH, default 12: word address width.
REQ-002 Ports SHALL be as follows (n = 0,1). Clock and reset:
- clk  in  1  sole clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
REQ-003 Requester n ports SHALL be:
- reqn  in  1  access request.
- wen  in  1  1 = write, 0 = read.
- addrn  in  ADDR_WIDTH  word address.
- wdatan  in  DATA_WIDTH  write data.
- lockn  in  1  hold ownership across consecutive accesses.
- gntn  out  1  request accepted this cycle.
- rvalidn  out  1  read data valid.
- rdatan  out  DATA_WIDTH  read data.
REQ-004 RAM-side ports (one dual-port RAM port) SHALL be:
- mem_addr  out  ADDR_WIDTH  port address.
- mem_we  out  1  port write enable.
- mem_din  out  DATA_WIDTH  port write data.
- mem_dout  in  DATA_WIDTH  port read data, combinational from mem_addr.

Function
REQ-005 States SHALL be IDLE, OWN0 and OWN1, plus a 1-bit round-robin pointer last (index of the last requester granted).
REQ-006 Grants SHALL be combinational from state and req; at most one gnt is high per cycle.
- In OWNn: gntn = reqn, and the other requester is never granted.
- In IDLE with one request: that requester is granted.
- In IDLE with both requesting: the requester != last is granted.
REQ-007 In a granted cycle, mem_addr, mem_we and mem_din SHALL equal the winner's addr, we and wdata. With no grant, mem_we = 0 and mem_addr/mem_din hold their last driven values.
REQ-008 A granted read SHALL capture mem_dout into rdatan at the clock edge, with rvalidn high for exactly the following cycle (latency 1). rdatan SHALL hold its value until the next read by that requester.
REQ-009 A granted write SHALL complete at the grant-cycle edge; no rvalid is produced.
REQ-010 Each grant SHALL set last = n at the edge.
REQ-011 IDLE SHALL transition to OWNn when gntn && lockn.
REQ-012 OWNn SHALL transition to IDLE on the first edge where lockn = 0, regardless of reqn. Ownership SHALL be retained while lockn = 1, even with reqn = 0.
REQ-013 A requester SHALL keep req and its access fields stable until gnt. An ungranted request is not queued by the arbiter.
REQ-014 Back-to-back grants to the same requester SHALL be allowed every cycle. A read in cycle t and a write to the same address in cycle t+1 SHALL return the pre-write data.
REQ-015 lockn asserted without a grant SHALL have no effect.

Reset
REQ-016 With rst_n = 0 at a clock edge, the block SHALL enter the following state:
- state = IDLE, last = 1 (requester 0 wins the first tie).
- rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
- mem_addr = 0, mem_din = 0.
REQ-017 During the reset cycle gnt0 = gnt1 = mem_we = 0. A read granted in the cycle before reset SHALL NOT produce rvalid.

Structure
REQ-018 A shared package SHALL hold the state enum (IDLE, OWN0, OWN1) and the requester-index constants.
REQ-019 A single sub-module SHALL be used: rr_arbiter2, the pure combinational two-way round-robin pick. All state and data registers stay in ram_port_arbiter.
REQ-020 The RTL target is 120-400 lines. The bench SHALL instantiate the arbiter with the team dual-port RAM model on one port.

Verification
REQ-021 Single read: req0 read addr 0x010 (RAM holds 0xDEADBEEF) -> gnt0 in the same cycle, rvalid0 = 1 with rdata0 = 0xDEADBEEF in the next cycle only.
REQ-022 Tie after reset: req0 and req1 both held -> grants alternate 0, 1, 0, 1 on successive cycles.
REQ-023 Lock burst:
- Stimulus: req1 with lock1 writes 0x100..0x103 in 4 consecutive cycles while req0 is held.
- Response: gnt0 stays low for all 4 cycles; gnt0 is granted in the cycle after lock1 drops.
REQ-024 Lock idle hold: OWN0 with req0 = 0 and lock0 = 1 for 3 cycles while req1 = 1 -> gnt1 stays low for all 3 cycles.
REQ-025 Reset mid-read: read granted at cycle t and rst_n = 0 at edge t+1 -> rvalid0 = 0 at t+1, rdata0 = 0, state IDLE.
REQ-026 Read-then-write: read 0x020 (value 0x11) at cycle t, write 0x22 to 0x020 at t+1 -> rdata = 0x11. A later read of 0x020 returns 0x22.
